riscv_decode_stage: RTL and testbench

- Registered, multi-lane RV32I decode stage between fetch and issue.
- Each cycle it accepts a bundle of LANES instruction words and decodes each lane into a riscv::decode_t. The result is held behind a valid/ready output with a 2-entry skid buffer, so in_ready is a registered signal.
- Extends the existing decode to U/UJ formats (LUI, AUIPC, JAL), JALR, per-lane illegal detection, flush, and optional bundle truncation at the first illegal lane.

---
 rtl/riscv_pkg.sv | 57 +++++
 rtl/riscv_lane_decoder.sv | 105 ++++++++++
 rtl/riscv_decode_stage.sv | 150 +++++++++++++++
 tb/tb_riscv_decode_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcodes, instruction formats, the per-lane
// decode record and the decode-stage FSM states.
package riscv;

  typedef enum logic [6:0] {
    OP_R       = 7'b0110011,
    OP_I_ARITH = 7'b0010011,
    OP_I_LOAD  = 7'b0000011,
    OP_S       = 7'b0100011,
    OP_SB      = 7'b1100011,
    OP_U_LUI   = 7'b0110111,
    OP_U_AUIPC = 7'b0010111,
    OP_UJ_JAL  = 7'b1101111,
    OP_I_JALR  = 7'b1100111
  } opcode_t;

  // IT_NONE keeps an all-zero decode distinguishable from a real R-type.
  typedef enum logic [2:0] {
    IT_NONE = 3'd0,
    R_TYPE  = 3'd1,
    I_TYPE  = 3'd2,
    S_TYPE  = 3'd3,
    SB_TYPE = 3'd4,
    U_TYPE  = 3'd5,
    UJ_TYPE = 3'd6
  } itype_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef struct packed {
    logic [6:0]  opcode;
    itype_t      i_type;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu_func;
    logic [4:0]  shiftamt;
    logic [2:0]  branch;
    logic [2:0]  width;
  } decode_t;

  typedef struct packed {
    decode_t dec;
    logic    illegal;
  } lane_decode_t;

  localparam int DECODE_W = $bits(decode_t);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/riscv_lane_decoder.sv
// Combinational RV32I decode of a single instruction word into decode_t,
// with legality checking. Illegal words produce an all-zero decode.
module riscv_lane_decoder
  import riscv::*;
(
  input  logic [31:0]  instr,
  output lane_decode_t res
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  decode_t    d;
  logic       ill;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];

  always_comb begin
    d        = '0;
    ill      = 1'b0;
    d.opcode = op;
    case (op)
      OP_R: begin
        d.i_type   = R_TYPE;
        d.rd       = instr[11:7];
        d.rs1      = instr[19:15];
        d.rs2      = instr[24:20];
        d.alu_func = {f7[5], f3};
        if (!((f7 == 7'b0000000) ||
              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
          ill = 1'b1;
      end
      OP_I_ARITH: begin
        d.i_type   = I_TYPE;
        d.rd       = instr[11:7];
        d.rs1      = instr[19:15];
        d.imm      = {{20{instr[31]}}, instr[31:20]};
        d.alu_func = {1'b0, f3};
        if (f3 == 3'b001) begin
          d.shiftamt = instr[24:20];
          if (f7 != 7'b0000000) ill = 1'b1;
        end else if (f3 == 3'b101) begin
          d.shiftamt = instr[24:20];
          d.alu_func = {f7[5], f3};
          if (f7 != 7'b0000000 && f7 != 7'b0100000) ill = 1'b1;
        end
      end
      OP_I_LOAD: begin
        d.i_type   = I_TYPE;
        d.rd       = instr[11:7];
        d.rs1      = instr[19:15];
        d.imm      = {{20{instr[31]}}, instr[31:20]};
        d.alu_func = ALU_ADD;
        d.width    = f3;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      end
      OP_S: begin
        d.i_type   = S_TYPE;
        d.rs1      = instr[19:15];
        d.rs2      = instr[24:20];
        d.imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        d.alu_func = ALU_ADD;
        d.width    = f3;
        if (f3 > 3'b010) ill = 1'b1;
      end
      OP_SB: begin
        d.i_type   = SB_TYPE;
        d.rs1      = instr[19:15];
        d.rs2      = instr[24:20];
        d.imm      = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        d.alu_func = ALU_SUB;
        d.branch   = f3;
        if (f3 == 3'b010 || f3 == 3'b011) ill = 1'b1;
      end
      OP_U_LUI, OP_U_AUIPC: begin
        d.i_type   = U_TYPE;
        d.rd       = instr[11:7];
        d.imm      = {instr[31:12], 12'b0};
        d.alu_func = ALU_ADD;
      end
      OP_UJ_JAL: begin
        d.i_type   = UJ_TYPE;
        d.rd       = instr[11:7];
        d.imm      = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        d.alu_func = ALU_ADD;
      end
      OP_I_JALR: begin
        d.i_type   = I_TYPE;
        d.rd       = instr[11:7];
        d.rs1      = instr[19:15];
        d.imm      = {{20{instr[31]}}, instr[31:20]};
        d.alu_func = ALU_ADD;
        if (f3 != 3'b000) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) ill = 1'b1;
  end

  assign res.dec     = ill ? '0 : d;
  assign res.illegal = ill;

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered multi-lane decode stage with a 2-entry skid buffer.
// Handshake: a bundle moves on accept = in_valid & in_ready and leaves on drain = out_valid & out_ready.
module riscv_decode_stage
  import riscv::*;
#(
  parameter int unsigned LANES            = 2,
  parameter bit          TRUNC_ON_ILLEGAL = 1'b1,
  parameter int unsigned PC_W             = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*LANES-1:0]       in_instr,
  input  logic [LANES-1:0]          in_lane_mask,
  input  logic [PC_W-1:0]           in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DECODE_W-1:0] out_decode,
  output logic [LANES-1:0]          out_lane_valid,
  output logic [LANES-1:0]          out_illegal,
  output logic [PC_W-1:0]           out_pc,
  output stage_state_t              dbg_state
);

  lane_decode_t              lane_res [LANES];
  logic [LANES*DECODE_W-1:0] nxt_dec;
  logic [LANES-1:0]          nxt_lv;
  logic [LANES-1:0]          nxt_ill;
  logic                      seen_ill;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    riscv_lane_decoder u_dec (
      .instr (in_instr[32*i +: 32]),
      .res   (lane_res[i])
    );
  end

  // Masked lanes are blanked; with truncation, everything above the
  // lowest illegal lane is blanked too.
  always_comb begin
    nxt_dec  = '0;
    nxt_lv   = '0;
    nxt_ill  = '0;
    seen_ill = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (in_lane_mask[i] && !(TRUNC_ON_ILLEGAL && seen_ill)) begin
        nxt_lv[i]                       = 1'b1;
        nxt_ill[i]                      = lane_res[i].illegal;
        nxt_dec[i*DECODE_W +: DECODE_W] = lane_res[i].dec;
      end
      if (nxt_ill[i]) seen_ill = 1'b1;
    end
  end

  stage_state_t              state_q, state_d;
  logic                      in_ready_q;
  logic                      accept, drain;
  logic                      load_main, load_skid, move_skid;
  logic [LANES*DECODE_W-1:0] main_dec_q, skid_dec_q;
  logic [LANES-1:0]          main_lv_q, skid_lv_q;
  logic [LANES-1:0]          main_ill_q, skid_ill_q;
  logic [PC_W-1:0]           main_pc_q, skid_pc_q;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_d   = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_dec_q <= '0;
      main_lv_q  <= '0;
      main_ill_q <= '0;
      main_pc_q  <= '0;
      skid_dec_q <= '0;
      skid_lv_q  <= '0;
      skid_ill_q <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
      if (load_main) begin
        main_dec_q <= nxt_dec;
        main_lv_q  <= nxt_lv;
        main_ill_q <= nxt_ill;
        main_pc_q  <= in_pc;
      end else if (move_skid) begin
        main_dec_q <= skid_dec_q;
        main_lv_q  <= skid_lv_q;
        main_ill_q <= skid_ill_q;
        main_pc_q  <= skid_pc_q;
      end
      if (load_skid) begin
        skid_dec_q <= nxt_dec;
        skid_lv_q  <= nxt_lv;
        skid_ill_q <= nxt_ill;
        skid_pc_q  <= in_pc;
      end
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = (state_q != EMPTY);
  assign out_decode     = main_dec_q;
  assign out_lane_valid = main_lv_q;
  assign out_illegal    = main_ill_q;
  assign out_pc         = main_pc_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: decode vectors, truncation on/off,
// masking, skid backpressure ordering, flush and reset in the full state.
module tb_riscv_decode_stage;
  import riscv::*;

  localparam int DW = DECODE_W;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, out_ready;
  logic [63:0]     in_instr;
  logic [1:0]      in_lane_mask;
  logic [31:0]     in_pc;
  logic            in_ready, out_valid;
  logic [2*DW-1:0] out_decode;
  logic [1:0]      out_lane_valid, out_illegal;
  logic [31:0]     out_pc;
  stage_state_t    dbg_state;
  logic            nt_in_ready, nt_out_valid;
  logic [2*DW-1:0] nt_out_decode;
  logic [1:0]      nt_out_lane_valid, nt_out_illegal;
  logic [31:0]     nt_out_pc;
  stage_state_t    nt_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0]     exp_q[$];
  logic [2*DW-1:0] exp_dec_q[$];
  logic [2*DW-1:0] exp_basic, exp_bl, exp_ss;

  always #5 clk = ~clk;

  riscv_decode_stage #(.LANES(2), .TRUNC_ON_ILLEGAL(1'b1), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lane_mask(in_lane_mask), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_decode(out_decode),
    .out_lane_valid(out_lane_valid), .out_illegal(out_illegal), .out_pc(out_pc),
    .dbg_state(dbg_state)
  );

  riscv_decode_stage #(.LANES(2), .TRUNC_ON_ILLEGAL(1'b0), .PC_W(32)) dut_nt (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(nt_in_ready),
    .in_instr(in_instr), .in_lane_mask(in_lane_mask), .in_pc(in_pc),
    .out_valid(nt_out_valid), .out_ready(out_ready), .out_decode(nt_out_decode),
    .out_lane_valid(nt_out_lane_valid), .out_illegal(nt_out_illegal), .out_pc(nt_out_pc),
    .dbg_state(nt_dbg_state)
  );

  function automatic decode_t mk(input itype_t t, input logic [6:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm,
                                 input logic [3:0] alu, input logic [4:0] sh,
                                 input logic [2:0] br, input logic [2:0] wd);
    decode_t d;
    d.opcode = op; d.i_type = t; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
    d.imm = imm; d.alu_func = alu; d.shiftamt = sh; d.branch = br; d.width = wd;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i1, input logic [31:0] i0,
                       input logic [1:0] mask, input logic [31:0] pc);
    in_valid     = 1'b1;
    in_instr     = {i1, i0};
    in_lane_mask = mask;
    in_pc        = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_lane_mask = '0; in_pc = '0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_checks++; if (out_decode !== '0 || out_lane_valid !== 2'b00 || out_illegal !== 2'b00 || out_pc !== 32'h0)
      begin n_fail++; $display("FAIL reset_outputs dec %h lv %b ill %b pc %h exp all zero", out_decode, out_lane_valid, out_illegal, out_pc); end
    n_checks++; if (dbg_state !== EMPTY) begin n_fail++; $display("FAIL reset_state got %0d exp EMPTY", dbg_state); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    offer(32'h402081B3, 32'h00500093, 2'b11, 32'h100);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %b exp 1", out_valid); end
    n_checks++; if (out_decode !== exp_basic) begin n_fail++; $display("FAIL basic_decode got %h exp %h", out_decode, exp_basic); end
    n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL basic_pc got %h exp 100", out_pc); end
    n_checks++; if (out_lane_valid !== 2'b11 || out_illegal !== 2'b00)
      begin n_fail++; $display("FAIL basic_masks lv %b ill %b exp 11 00", out_lane_valid, out_illegal); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_branch_lui();
    offer(32'h123452B7, 32'hFE208CE3, 2'b11, 32'h104);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_decode !== exp_bl) begin n_fail++; $display("FAIL branch_lui_decode got %h exp %h", out_decode, exp_bl); end
    n_checks++; if (out_lane_valid !== 2'b11 || out_illegal !== 2'b00 || out_pc !== 32'h104)
      begin n_fail++; $display("FAIL branch_lui_meta lv %b ill %b pc %h exp 11 00 104", out_lane_valid, out_illegal, out_pc); end
    tick();
  endtask

  task automatic test_shift_store();
    offer(32'h0020A423, 32'h4030D093, 2'b11, 32'h108);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_decode !== exp_ss) begin n_fail++; $display("FAIL shift_store_decode got %h exp %h", out_decode, exp_ss); end
    tick();
  endtask

  task automatic test_illegal_trunc();
    logic [2*DW-1:0] e;
    offer(32'h00500093, 32'hFFFFFFFF, 2'b11, 32'h10C);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_lane_valid !== 2'b01 || out_illegal !== 2'b01)
      begin n_fail++; $display("FAIL trunc_masks lv %b ill %b exp 01 01", out_lane_valid, out_illegal); end
    n_checks++; if (out_decode !== '0) begin n_fail++; $display("FAIL trunc_decode got %h exp 0", out_decode); end
    e = {mk(I_TYPE, 7'h13, 5'd1, 5'd0, 5'd0, 32'd5, ALU_ADD, 5'd0, 3'd0, 3'd0), DW'(0)};
    n_checks++; if (nt_out_lane_valid !== 2'b11 || nt_out_illegal !== 2'b01)
      begin n_fail++; $display("FAIL notrunc_masks lv %b ill %b exp 11 01", nt_out_lane_valid, nt_out_illegal); end
    n_checks++; if (nt_out_decode !== e) begin n_fail++; $display("FAIL notrunc_decode got %h exp %h", nt_out_decode, e); end
    tick();
    // lane1 illegal (JALR funct3=001): lowest illegal is the top lane, nothing truncated
    offer(32'h000090E7, 32'h010000EF, 2'b11, 32'h110);
    tick();
    in_valid = 1'b0;
    e = {DW'(0), mk(UJ_TYPE, 7'h6F, 5'd1, 5'd0, 5'd0, 32'd16, ALU_ADD, 5'd0, 3'd0, 3'd0)};
    n_checks++; if (out_lane_valid !== 2'b11 || out_illegal !== 2'b10)
      begin n_fail++; $display("FAIL jalr_ill_masks lv %b ill %b exp 11 10", out_lane_valid, out_illegal); end
    n_checks++; if (out_decode !== e) begin n_fail++; $display("FAIL jal_decode got %h exp %h", out_decode, e); end
    tick();
  endtask

  task automatic test_mask();
    logic [2*DW-1:0] e;
    offer(32'hFFFFFFFF, 32'h00500093, 2'b01, 32'h114);
    tick();
    in_valid = 1'b0;
    e = {DW'(0), mk(I_TYPE, 7'h13, 5'd1, 5'd0, 5'd0, 32'd5, ALU_ADD, 5'd0, 3'd0, 3'd0)};
    n_checks++; if (out_lane_valid !== 2'b01 || out_illegal !== 2'b00 || out_decode !== e)
      begin n_fail++; $display("FAIL masked_lane lv %b ill %b dec %h exp 01 00 %h", out_lane_valid, out_illegal, out_decode, e); end
    tick();
    offer(32'h00500093, 32'h00500093, 2'b00, 32'h118);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_lane_valid !== 2'b00 || out_illegal !== 2'b00 || out_decode !== '0 || out_pc !== 32'h118)
      begin n_fail++; $display("FAIL empty_mask v %b lv %b ill %b dec %h pc %h exp 1 00 00 0 118", out_valid, out_lane_valid, out_illegal, out_decode, out_pc); end
    tick();
  endtask

  task automatic test_back_to_back();
    int  drained;
    bit  c_sent;
    bit  took;
    out_ready = 1'b0;
    offer(32'h402081B3, 32'h00500093, 2'b11, 32'h200);
    exp_q.push_back(32'h200); exp_dec_q.push_back(exp_basic);
    tick();
    offer(32'h123452B7, 32'hFE208CE3, 2'b11, 32'h300);
    exp_q.push_back(32'h300); exp_dec_q.push_back(exp_bl);
    tick();
    n_checks++; if (in_ready !== 1'b0 || dbg_state !== TWO)
      begin n_fail++; $display("FAIL bp_full in_ready %b state %0d exp 0 TWO", in_ready, dbg_state); end
    offer(32'h0020A423, 32'h4030D093, 2'b11, 32'h400);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_decode !== exp_basic || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_stall v %b pc %h rdy %b exp 1 200 0", out_valid, out_pc, in_ready); end
    end
    out_ready = 1'b1;
    drained = 0;
    c_sent = 1'b0;
    for (int k = 0; k < 20 && !(c_sent && exp_q.size() == 0); k++) begin
      took = 1'b0;
      if (in_valid && in_ready) begin
        exp_q.push_back(32'h400); exp_dec_q.push_back(exp_ss);
        took = 1'b1;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra pc %h exp none", out_pc);
        end else begin
          if (out_pc !== exp_q[0] || out_decode !== exp_dec_q[0]) begin
            n_fail++; $display("FAIL bp_order pc %h exp %h", out_pc, exp_q[0]);
          end
          void'(exp_q.pop_front()); void'(exp_dec_q.pop_front());
        end
        drained++;
      end
      tick();
      if (took) begin in_valid = 1'b0; c_sent = 1'b1; end
    end
    n_checks++; if (drained != 3 || exp_q.size() != 0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL bp_count drained %0d left %0d v %b exp 3 0 0", drained, exp_q.size(), out_valid); end
  endtask

  task automatic test_flush();
    logic [2*DW-1:0] e;
    out_ready = 1'b0;
    offer(32'h402081B3, 32'h00500093, 2'b11, 32'h500);
    tick();
    offer(32'h402081B3, 32'h00500093, 2'b11, 32'h600);
    tick();
    n_checks++; if (dbg_state !== TWO) begin n_fail++; $display("FAIL flush_setup state %0d exp TWO", dbg_state); end
    offer(32'h402081B3, 32'h00500093, 2'b11, 32'h700);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_hs v %b rdy %b exp 0 1", out_valid, in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak v %b pc %h exp 0", out_valid, out_pc); end
    end
    offer(32'h123452B7, 32'h010000EF, 2'b11, 32'h800);
    tick();
    in_valid = 1'b0;
    e = {mk(U_TYPE, 7'h37, 5'd5, 5'd0, 5'd0, 32'h12345000, ALU_ADD, 5'd0, 3'd0, 3'd0),
         mk(UJ_TYPE, 7'h6F, 5'd1, 5'd0, 5'd0, 32'd16, ALU_ADD, 5'd0, 3'd0, 3'd0)};
    n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h800 || out_decode !== e)
      begin n_fail++; $display("FAIL post_flush v %b pc %h dec %h exp 1 800 %h", out_valid, out_pc, out_decode, e); end
    tick();
  endtask

  task automatic test_reset_in_two();
    out_ready = 1'b0;
    offer(32'h402081B3, 32'h00500093, 2'b11, 32'h900);
    tick();
    offer(32'h000090E7, 32'hFFFFFFFF, 2'b11, 32'hA00);
    tick();
    n_checks++; if (dbg_state !== TWO) begin n_fail++; $display("FAIL rst2_setup state %0d exp TWO", dbg_state); end
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== EMPTY)
      begin n_fail++; $display("FAIL rst2_hs v %b rdy %b state %0d exp 0 1 EMPTY", out_valid, in_ready, dbg_state); end
    n_checks++; if (out_decode !== '0 || out_lane_valid !== 2'b00 || out_illegal !== 2'b00 || out_pc !== 32'h0)
      begin n_fail++; $display("FAIL rst2_zero dec %h lv %b ill %b pc %h exp all zero", out_decode, out_lane_valid, out_illegal, out_pc); end
  endtask

  initial begin
    exp_basic = {mk(R_TYPE, 7'h33, 5'd3, 5'd1, 5'd2, 32'd0, ALU_SUB, 5'd0, 3'd0, 3'd0),
                 mk(I_TYPE, 7'h13, 5'd1, 5'd0, 5'd0, 32'd5, ALU_ADD, 5'd0, 3'd0, 3'd0)};
    exp_bl    = {mk(U_TYPE, 7'h37, 5'd5, 5'd0, 5'd0, 32'h12345000, ALU_ADD, 5'd0, 3'd0, 3'd0),
                 mk(SB_TYPE, 7'h63, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, ALU_SUB, 5'd0, 3'b000, 3'd0)};
    exp_ss    = {mk(S_TYPE, 7'h23, 5'd0, 5'd1, 5'd2, 32'd8, ALU_ADD, 5'd0, 3'd0, 3'b010),
                 mk(I_TYPE, 7'h13, 5'd1, 5'd1, 5'd0, 32'h00000403, 4'b1101, 5'd3, 3'd0, 3'd0)};
    test_reset();
    test_basic();
    test_branch_lui();
    test_shift_store();
    test_illegal_trunc();
    test_mask();
    test_back_to_back();
    test_flush();
    test_reset_in_two();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
